scan_fsm: RTL and testbench
===========================

Name: scan_fsm

Overview:
- Pixel-matrix scan sequencer that sits directly upstream of the top-level resource arbiter.
- Started by the arbiter's scan-go line; walks every pixel row by row, column by column.
- Per pixel: drives the chip row/column select shift registers and the key latch, waits for analog settling, runs one ADC conversion and writes the 12-bit sample to block RAM.
- All RAM addressing goes through the shared row/column counter control words; a one-cycle scan-end pulse reports completion.

Parameters:
- N_ROWS, 24, rows in the pixel matrix (2..31)
- N_COLS, 24, columns in the pixel matrix (2..31)
- SETTLE_CYCLES, 8, wait cycles after column key latch before ADC start (>=1)
- ROW_RST_CYCLES, 4, cycles o_row_rst is held at the start of each row (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_go  in  1  scan enable from arbiter; level, held high for the whole scan
- i_adc_done  in  1  conversion complete, one-cycle pulse
- i_adc_data  in  12  conversion result, valid while i_adc_done=1
- o_adc_start  out  1  one-cycle conversion request
- o_col_control  out  5  column counter control: bit4=clear, bit0=increment, bits3..1=0
- o_row_control  out  5  row counter control, same encoding
- o_ram_wren  out  1  RAM write strobe
- o_ram_data  out  12  RAM write data
- o_row_reg_data  out  1  serial bit into chip row select register
- o_row_reg_write  out  1  row register shift strobe
- o_col_reg_data  out  1  serial bit into chip column select register
- o_col_reg_write  out  1  column register shift strobe
- o_key_wren  out  1  latch shift-register contents to pixel drivers
- o_row_rst  out  1  pixel row reset
- o_scan_end  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, state IDLE, row/col indices 0.
- Outputs are ORed with other sequencers downstream, so every output except o_col_control/o_row_control is exactly 0 outside its active cycle. o_ram_data is 0 whenever o_ram_wren=0.
- States: IDLE, ROW_SHIFT, ROW_KEY, ROW_RST, COL_SHIFT, COL_KEY, SETTLE, CONVERT, WRITE, DONE, HOLD.
- IDLE:
  - control words = 5'b10000 (clear).
  - i_go=1 -> ROW_SHIFT with r=0, c=0.
- ROW_SHIFT (1 cycle):
  - o_row_reg_write=1; o_row_reg_data=1 if r==0 else 0, so a single one-hot bit walks the register.
  - Next state ROW_KEY.
- ROW_KEY (1 cycle): o_key_wren=1 -> ROW_RST.
- ROW_RST: o_row_rst=1 for exactly ROW_RST_CYCLES cycles -> COL_SHIFT.
- COL_SHIFT (1 cycle):
  - o_col_reg_write=1; o_col_reg_data=1 if c==0 else 0.
  - Next state COL_KEY.
- COL_KEY (1 cycle): o_key_wren=1 -> SETTLE.
- SETTLE: SETTLE_CYCLES cycles -> CONVERT.
- CONVERT:
  - o_adc_start=1 on the first cycle only; wait for i_adc_done and capture i_adc_data in the same cycle -> WRITE.
  - A done pulse that arrives outside CONVERT is ignored.
- WRITE (1 cycle):
  - o_ram_wren=1, o_ram_data=captured sample.
  - Address is the current counter value, which is stable during WRITE.
- Counter control:
  - Default is 5'b00000 in all states except IDLE/DONE/HOLD.
  - In the cycle after WRITE, o_col_control=5'b00001 (increment).
  - At end of row (c==N_COLS-1): o_col_control=5'b10000 and o_row_control=5'b00001.
- After WRITE:
  - c<N_COLS-1: c++ -> COL_SHIFT.
  - c==N_COLS-1, r<N_ROWS-1: c=0, r++ -> ROW_SHIFT.
  - Last pixel: -> DONE.
- Timing:
  - Per-pixel latency = 4 + SETTLE_CYCLES + ADC latency.
  - Per-row overhead = 2 + ROW_RST_CYCLES.
- DONE (1 cycle):
  - o_scan_end=1, control words = 5'b10000.
  - Next state HOLD.
- HOLD: outputs 0, control words 5'b10000; waits for i_go=0 -> IDLE. This prevents a re-scan while the arbiter has not yet dropped go.
- Abort: i_go=0 in any active state -> IDLE next cycle.
  - No o_scan_end, no RAM write.
  - A pending ADC result is discarded.
- Row/col indices are 5-bit; they never wrap, because terminal compares use N-1.
- Reset mid-operation: immediate return to reset values on rst assertion.

Test Plan:
1. N_ROWS=2, N_COLS=3, SETTLE=2, ROW_RST=2; ADC returns done 3 cycles after start with data=0x100+pixel index -> exactly 6 o_ram_wren pulses with data 0x100..0x105; 2 row-write strobes (data 1,0); 6 col-write strobes (data 1,0,0 per row); o_scan_end pulses once, 1 cycle after the 6th write.
2. Same configuration -> per-pixel cycles from COL_SHIFT to WRITE = 4+2+3; 8 o_key_wren pulses total; o_row_rst high for 2 cycles per row.
3. Keep i_go=1 after o_scan_end for 10 cycles -> no further activity, all outputs 0, control words 5'b10000; drop i_go then re-raise -> new scan starts with row data bit 1.
4. Drop i_go during CONVERT of pixel 2, then deliver i_adc_done -> no write, no o_scan_end; FSM returns to IDLE with control words 5'b10000.
5. Assert rst during SETTLE -> all outputs 0 the same cycle; after release with i_go=1, the scan restarts from pixel 0.
6. Inject i_adc_done during SETTLE -> ignored; the sample written to RAM is the one captured in CONVERT.

Source files
------------

// File: rtl/scan_fsm_if.sv
// Handshake/bus bundle between the scan sequencer and its surroundings
// (arbiter go line, ADC, block RAM, chip shift registers).
interface scan_fsm_if;
  logic        i_go;
  logic        i_adc_done;
  logic [11:0] i_adc_data;
  logic        o_adc_start;
  logic [4:0]  o_col_control;
  logic [4:0]  o_row_control;
  logic        o_ram_wren;
  logic [11:0] o_ram_data;
  logic        o_row_reg_data;
  logic        o_row_reg_write;
  logic        o_col_reg_data;
  logic        o_col_reg_write;
  logic        o_key_wren;
  logic        o_row_rst;
  logic        o_scan_end;

  // sequencer side
  modport master (
    input  i_go, i_adc_done, i_adc_data,
    output o_adc_start, o_col_control, o_row_control, o_ram_wren, o_ram_data,
           o_row_reg_data, o_row_reg_write, o_col_reg_data, o_col_reg_write,
           o_key_wren, o_row_rst, o_scan_end
  );

  // environment side (arbiter / ADC / RAM / chip)
  modport slave (
    output i_go, i_adc_done, i_adc_data,
    input  o_adc_start, o_col_control, o_row_control, o_ram_wren, o_ram_data,
           o_row_reg_data, o_row_reg_write, o_col_reg_data, o_col_reg_write,
           o_key_wren, o_row_rst, o_scan_end
  );
endinterface

// File: rtl/scan_fsm.sv
// Pixel-matrix scan sequencer: walks rows/columns, selects each pixel via the
// chip shift registers, settles, converts once and writes the sample to RAM.
// All outputs except the counter control words are zero outside their active
// cycle because they are ORed with other sequencers downstream.
module scan_fsm #(
  parameter int N_ROWS         = 24,
  parameter int N_COLS         = 24,
  parameter int SETTLE_CYCLES  = 8,
  parameter int ROW_RST_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  scan_fsm_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE, ROW_SHIFT, ROW_KEY, ROW_RST, COL_SHIFT, COL_KEY,
    SETTLE, CONVERT, WRITE, DONE, HOLD
  } state_t;

  localparam int CW = 16;
  localparam logic [4:0] CTL_CLR = 5'b10000;
  localparam logic [4:0] CTL_INC = 5'b00001;

  state_t          state, state_nx;
  logic [4:0]      r, c;
  logic [CW-1:0]   cnt;
  logic [11:0]     sample;
  logic            after_write;   // previous cycle was WRITE: counters advance now
  logic            conv_issued;   // ADC start already pulsed in this CONVERT
  logic            last_col, last_row;

  assign last_col = (c == 5'(N_COLS - 1));
  assign last_row = (r == 5'(N_ROWS - 1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: scan walk, with go-drop aborting any active state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.i_go) state_nx = ROW_SHIFT;
      ROW_SHIFT: state_nx = ROW_KEY;
      ROW_KEY:   state_nx = ROW_RST;
      ROW_RST:   if (cnt == CW'(ROW_RST_CYCLES - 1)) state_nx = COL_SHIFT;
      COL_SHIFT: state_nx = COL_KEY;
      COL_KEY:   state_nx = SETTLE;
      SETTLE:    if (cnt == CW'(SETTLE_CYCLES - 1)) state_nx = CONVERT;
      CONVERT:   if (bus.i_adc_done) state_nx = WRITE;
      WRITE: begin
        if (!last_col)      state_nx = COL_SHIFT;
        else if (!last_row) state_nx = ROW_SHIFT;
        else                state_nx = DONE;
      end
      DONE:      state_nx = HOLD;
      HOLD:      if (!bus.i_go) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (!bus.i_go && state != IDLE && state != HOLD) state_nx = IDLE;
  end

  // datapath: wait counter, pixel indices, sample capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      c           <= '0;
      cnt         <= '0;
      sample      <= '0;
      after_write <= 1'b0;
      conv_issued <= 1'b0;
    end else begin
      after_write <= (state == WRITE);
      conv_issued <= (state == CONVERT) && (state_nx == CONVERT);
      if ((state == ROW_RST || state == SETTLE) && state_nx == state) cnt <= cnt + 1'b1;
      else                                                           cnt <= '0;
      if (state == CONVERT && bus.i_adc_done) sample <= bus.i_adc_data;
      if (state_nx == IDLE) begin
        r <= '0;
        c <= '0;
      end else if (state == WRITE) begin
        if (!last_col) c <= c + 5'd1;
        else if (!last_row) begin
          c <= '0;
          r <= r + 5'd1;
        end
      end
    end
  end

  // Moore outputs; control words are forced low while reset is asserted
  always_comb begin
    bus.o_adc_start     = 1'b0;
    bus.o_col_control   = '0;
    bus.o_row_control   = '0;
    bus.o_ram_wren      = 1'b0;
    bus.o_ram_data      = '0;
    bus.o_row_reg_data  = 1'b0;
    bus.o_row_reg_write = 1'b0;
    bus.o_col_reg_data  = 1'b0;
    bus.o_col_reg_write = 1'b0;
    bus.o_key_wren      = 1'b0;
    bus.o_row_rst       = 1'b0;
    bus.o_scan_end      = 1'b0;
    case (state)
      IDLE, HOLD: begin
        bus.o_col_control = CTL_CLR;
        bus.o_row_control = CTL_CLR;
      end
      ROW_SHIFT: begin
        bus.o_row_reg_write = 1'b1;
        bus.o_row_reg_data  = (r == 5'd0);
        if (after_write) begin
          bus.o_col_control = CTL_CLR;
          bus.o_row_control = CTL_INC;
        end
      end
      ROW_KEY:   bus.o_key_wren = 1'b1;
      ROW_RST:   bus.o_row_rst  = 1'b1;
      COL_SHIFT: begin
        bus.o_col_reg_write = 1'b1;
        bus.o_col_reg_data  = (c == 5'd0);
        if (after_write) bus.o_col_control = CTL_INC;
      end
      COL_KEY:   bus.o_key_wren  = 1'b1;
      CONVERT:   bus.o_adc_start = !conv_issued;
      WRITE: begin
        bus.o_ram_wren = 1'b1;
        bus.o_ram_data = sample;
      end
      DONE: begin
        bus.o_scan_end    = 1'b1;
        bus.o_col_control = CTL_CLR;
        bus.o_row_control = CTL_CLR;
      end
      default: ;
    endcase
    if (rst) begin
      bus.o_col_control = '0;
      bus.o_row_control = '0;
    end
  end

endmodule

// File: tb/tb_scan_fsm.sv
// Bench for scan_fsm: builds the expected per-cycle output timeline of a scan
// from the pixel walk rules, plays matching stimulus, compares every cycle.
module tb_scan_fsm;
  localparam int NR = 2, NC = 3, SC = 2, RC = 2;

  typedef struct packed {
    logic       adc_start;
    logic [4:0] col_ctl;
    logic [4:0] row_ctl;
    logic       wren;
    logic [11:0] data;
    logic       rrd, rrw, crd, crw, key, rowrst, scan_end;
  } outv_t;

  typedef struct packed {
    logic rst, go, done;
    logic [11:0] data;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_fsm_if bus();
  scan_fsm #(.N_ROWS(NR), .N_COLS(NC), .SETTLE_CYCLES(SC), .ROW_RST_CYCLES(RC))
    dut (.clk(clk), .rst(rst), .bus(bus.master));

  outv_t dut_o;
  assign dut_o = {bus.o_adc_start, bus.o_col_control, bus.o_row_control, bus.o_ram_wren,
                  bus.o_ram_data, bus.o_row_reg_data, bus.o_row_reg_write, bus.o_col_reg_data,
                  bus.o_col_reg_write, bus.o_key_wren, bus.o_row_rst, bus.o_scan_end};

  // model timeline of one scan and the play queues
  outv_t tl_exp[$];  stim_t tl_stim[$];
  int    settle_q[$], conv_q[$];
  int    done_idx;
  outv_t exp_q[$];   stim_t stim_q[$];

  outv_t exp_cur;
  logic  chk_en = 1'b0;
  int    cyc = 0;
  int    errors = 0, checks = 0;
  int    n_wr = 0, n_key = 0, n_rowrst = 0, n_end = 0, n_crw = 0, n_rrw = 0, n_sum = 0;

  // literal-check request handed to the compare process
  logic  lit_vld = 1'b0;
  string lit_name;
  int    lit_got, lit_exp;

  // the single compare process
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_o !== exp_cur) begin
        errors++;
        $display("FAIL cycle_%0d outputs got=%h exp=%h", cyc, dut_o, exp_cur);
      end
      if (dut_o.wren)     begin n_wr++; n_sum += int'(dut_o.data); end
      if (dut_o.key)      n_key++;
      if (dut_o.rowrst)   n_rowrst++;
      if (dut_o.scan_end) n_end++;
      if (dut_o.crw)      n_crw++;
      if (dut_o.rrw)      n_rrw++;
    end
    if (lit_vld) begin
      checks++;
      if (lit_got !== lit_exp) begin
        errors++;
        $display("FAIL %s got=%0d exp=%0d", lit_name, lit_got, lit_exp);
      end
    end
  end

  task automatic lit(input string name, input int got, input int expv);
    lit_name = name; lit_got = got; lit_exp = expv; lit_vld = 1'b1;
    @(negedge clk); #1;
    lit_vld = 1'b0;
  endtask

  function automatic outv_t idle_o();
    outv_t o = '0;
    o.col_ctl = 5'b10000;
    o.row_ctl = 5'b10000;
    return o;
  endfunction

  task automatic tl_push(input outv_t o, input bit done, input logic [11:0] d);
    stim_t s;
    s.rst = 1'b0; s.go = 1'b1; s.done = done;
    s.data = done ? d : 12'($urandom);
    tl_exp.push_back(o);
    tl_stim.push_back(s);
  endtask

  task automatic q_push(input bit r, input bit go, input bit done, input outv_t o);
    stim_t s;
    s.rst = r; s.go = go; s.done = done; s.data = 12'($urandom);
    stim_q.push_back(s);
    exp_q.push_back(o);
  endtask

  // Expected scan: IDLE(go seen), then per row: shift, key, RC reset cycles;
  // per pixel: col shift, key, SC settle, convert (lat+1 cycles), write; DONE.
  task automatic build(input bit seq, input int lat_fixed, input bit spur_all);
    outv_t o;
    int lat, spur, pix;
    logic [11:0] smp;
    tl_exp.delete(); tl_stim.delete(); settle_q.delete(); conv_q.delete();
    tl_push(idle_o(), 1'b0, 12'h0);
    for (int r = 0; r < NR; r++) begin
      o = '0; o.rrw = 1'b1; o.rrd = (r == 0);
      if (r > 0) begin o.col_ctl = 5'b10000; o.row_ctl = 5'b00001; end
      tl_push(o, 1'b0, 12'h0);
      o = '0; o.key = 1'b1; tl_push(o, 1'b0, 12'h0);
      for (int k = 0; k < RC; k++) begin o = '0; o.rowrst = 1'b1; tl_push(o, 1'b0, 12'h0); end
      for (int c = 0; c < NC; c++) begin
        pix = r * NC + c;
        o = '0; o.crw = 1'b1; o.crd = (c == 0);
        if (c > 0) o.col_ctl = 5'b00001;
        tl_push(o, 1'b0, 12'h0);
        o = '0; o.key = 1'b1; tl_push(o, 1'b0, 12'h0);
        spur = -1;
        if (spur_all || (!seq && $urandom_range(0, 1) == 1)) spur = $urandom_range(0, SC - 1);
        settle_q.push_back(tl_exp.size());
        for (int s = 0; s < SC; s++) tl_push('0, (s == spur), 12'($urandom));
        lat = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 4);
        smp = seq ? 12'(12'h100 + pix) : 12'($urandom);
        conv_q.push_back(tl_exp.size());
        for (int k = 0; k <= lat; k++) begin
          o = '0; o.adc_start = (k == 0);
          tl_push(o, (k == lat), smp);
        end
        o = '0; o.wren = 1'b1; o.data = smp; tl_push(o, 1'b0, 12'h0);
      end
    end
    done_idx = tl_exp.size();
    o = idle_o(); o.scan_end = 1'b1; tl_push(o, 1'b0, 12'h0);
  endtask

  task automatic emit(input int n);
    for (int i = 0; i < n; i++) begin
      stim_q.push_back(tl_stim[i]);
      exp_q.push_back(tl_exp[i]);
    end
  endtask

  task automatic run_full(input int hold);
    emit(tl_exp.size());
    for (int i = 0; i < hold; i++) q_push(1'b0, 1'b1, 1'b0, idle_o());
    q_push(1'b0, 1'b0, 1'b0, idle_o());
    q_push(1'b0, 1'b0, 1'b0, idle_o());
  endtask

  // go drops in timeline cycle k; a late ADC done follows and must be ignored
  task automatic run_abort(input int k);
    stim_t s;
    emit(k);
    s = tl_stim[k]; s.go = 1'b0;
    stim_q.push_back(s);
    exp_q.push_back(tl_exp[k]);
    q_push(1'b0, 1'b0, 1'b1, idle_o());
    q_push(1'b0, 1'b0, 1'b0, idle_o());
    q_push(1'b0, 1'b0, 1'b0, idle_o());
  endtask

  // reset asserted in timeline cycle k with go still high
  task automatic run_rst(input int k);
    emit(k);
    q_push(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic play();
    for (int i = 0; i < stim_q.size(); i++) begin
      @(posedge clk); #1;
      rst            = stim_q[i].rst;
      bus.i_go       = stim_q[i].go;
      bus.i_adc_done = stim_q[i].done;
      bus.i_adc_data = stim_q[i].data;
      exp_cur        = exp_q[i];
      cyc++;
      chk_en         = 1'b1;
    end
    stim_q.delete(); exp_q.delete();
  endtask

  initial begin
    int w0, k0, e0, r0, s0, c0, rr0, wr_tl;
    rst = 1'b1; bus.i_go = 1'b0; bus.i_adc_done = 1'b0; bus.i_adc_data = '0;

    // reset state, then idle
    q_push(1'b1, 1'b0, 1'b0, '0);
    q_push(1'b1, 1'b0, 1'b0, '0);
    q_push(1'b0, 1'b0, 1'b0, idle_o());
    q_push(1'b0, 1'b0, 1'b0, idle_o());
    play();

    // nominal scan, ADC latency 3, data 0x100+pixel, go held 10 cycles after end
    build(1'b1, 3, 1'b0);
    @(negedge clk); #1;
    w0 = n_wr; k0 = n_key; e0 = n_end; r0 = n_rowrst; s0 = n_sum; c0 = n_crw; rr0 = n_rrw;
    run_full(10);
    play();
    @(negedge clk); #1;
    wr_tl = 0;
    foreach (tl_exp[i]) if (tl_exp[i].wren) wr_tl++;
    lit("model_done_idx", done_idx, 63);
    lit("model_settle0", settle_q[0], 7);
    lit("model_conv5", conv_q[5], 58);
    lit("model_writes", wr_tl, 6);
    lit("dut_writes", n_wr - w0, 6);
    lit("dut_write_sum", n_sum - s0, 1551);
    lit("dut_key_wren", n_key - k0, 8);
    lit("dut_row_rst", n_rowrst - r0, 4);
    lit("dut_scan_end", n_end - e0, 1);
    lit("dut_col_writes", n_crw - c0, 6);
    lit("dut_row_writes", n_rrw - rr0, 2);

    // re-raised go: new scan, a spurious done in every settle window
    build(1'b1, 3, 1'b1);
    run_full(0);
    play();

    // abort during CONVERT of pixel 2, done arrives afterwards
    build(1'b0, 3, 1'b0);
    run_abort(conv_q[2] + 1);
    play();

    // reset during SETTLE of pixel 1, then full rescan from pixel 0
    build(1'b0, 0, 1'b0);
    run_rst(settle_q[1] + 1);
    build(1'b0, 0, 1'b0);
    run_full(2);
    play();

    // randomized scans with random ADC latency and random abort points
    for (int n = 0; n < 12; n++) begin
      build(1'b0, 0, 1'b0);
      if ($urandom_range(0, 2) == 0) run_full($urandom_range(0, 5));
      else                           run_abort($urandom_range(1, done_idx));
      play();
    end

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
